decode_dispatch: RTL
====================

Name: decode_dispatch

Overview:
- Registered decode-and-dispatch stage between the instruction queue and the RS/ROB. It generalises the single-cycle decoder with parametrised widths, valid/ready handshakes, stall on back-pressure, flush, and regfile rename.
- Accepts one RV32I instruction per cycle into a decode register. It resolves operands against the regfile and the ROB, allocates the destination tag, and emits one registered dispatch packet.

Parameters:
XLEN, 32, data/immediate width
ROB_WIDTH, 4, ROB tag width; tag 0 reserved as "no dependency", usable tags 1..2^ROB_WIDTH-1
OP_WIDTH, 6, internal operation-code bus width
REG_WIDTH, 5, architectural register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  mispredict flush; discards all held state
inst_valid  in  1  queue has an instruction
inst  in  32  instruction word
inst_pc  in  XLEN  instruction PC
inst_ready  out  1  decode register can accept
rs1, rs2  out  REG_WIDTH  regfile read indices (combinational from decode register)
reg_value1, reg_value2  in  XLEN  regfile data
reg_busy1, reg_busy2  in  1  register renamed
reg_tag1, reg_tag2  in  ROB_WIDTH  rename tags
query_tag1, query_tag2  out  ROB_WIDTH  ROB lookup tags; 0 when not busy
rob_ready1, rob_ready2  in  1  ROB entry has its result
rob_value1, rob_value2  in  XLEN  ROB result values
rob_alloc_tag  in  ROB_WIDTH  next free ROB tag
rob_full, rs_full  in  1  back-pressure
rename_en  out  1  regfile rename write strobe (combinational)
rename_reg  out  REG_WIDTH  register being renamed
rename_tag  out  ROB_WIDTH  = rob_alloc_tag
dispatch_valid  out  1  one-cycle pulse per dispatched packet
out_op  out  OP_WIDTH  decoded operation
out_imm  out  XLEN  sign/zero-extended immediate
out_pc  out  XLEN  instruction PC
out_rd  out  REG_WIDTH  destination register
out_dest_tag  out  ROB_WIDTH  allocated ROB tag
out_operand1, out_operand2  out  XLEN  resolved values (0 if pending)
out_tag1, out_tag2  out  ROB_WIDTH  pending tags (0 if resolved)
cdb_valid  in  1  CDB broadcast (used only with optional feature)
cdb_tag  in  ROB_WIDTH  CDB tag
cdb_value  in  XLEN  CDB value

Behaviour:
- Reset (clk edge, rst=1): d_valid=0. All out_* = 0, out_op = NOP, dispatch_valid=0. Reset wins over all other inputs.
- Decode register states: EMPTY (d_valid=0) and HELD (d_valid=1).
- inst_ready = !d_valid || fire, where fire = d_valid && !rob_full && !rs_full && !flush.
- Capture: inst_valid && inst_ready && !flush -> decode register loads inst/inst_pc; state HELD.
- Simultaneous fire and capture: back-to-back, no bubble. Throughput is 1 instruction/cycle; latency is capture edge -> dispatch_valid at the next edge (2 edges total).
- HELD with rob_full or rs_full: hold the decode register, dispatch_valid=0, no rename.
- flush: next edge d_valid=0 and dispatch_valid=0. Flush takes priority over capture and fire; rename_en=0 in the flush cycle.
- Operand resolution (per source, combinational on the decode register):
  - rsN == 0 -> value 0, tag 0.
  - !reg_busyN -> reg_valueN, tag 0.
  - busy && rob_readyN -> rob_valueN, tag 0.
  - otherwise -> value 0, tag reg_tagN.
- Source usage by format:
  - LUI/AUIPC/JAL: rs1=rs2=0.
  - JALR/LOAD/OP-IMM: rs2=0.
  - BRANCH: rd=0.
  - STORE: rd=0.
- Decoding:
  - OP-IMM funct3=000 is always ADD.
  - SRAI/SRA are selected by inst[30].
  - Immediates are I/S/B/U/J per RV32I, sign-extended from inst[31].
- Rename: rename_en = fire && out-rd != 0. On fire, out_dest_tag = rob_alloc_tag.
- Illegal opcode or funct3: dispatched with op NOP, rd=0, no rename. The ROB still allocates the tag.
- All out_* update only on fire; they hold otherwise.

Optional Feature:
DECODE_CDB_BYPASS_EN
- Enabled: if cdb_valid && cdb_tag == a pending source tag in the fire cycle, the packet carries cdb_value with tag 0. This applies to each source independently and has priority below the rob_ready check.
- Disabled: the cdb_* ports are ignored, and the tag stays pending (the RS snoops later).

Test Plan:
- Reset with inst_valid=1 -> dispatch_valid=0, inst_ready=1 after reset release, all out_* = 0.
- ADDI x5,x0,-1 with regfile idle -> one cycle after capture: dispatch_valid=1, out_op=ADD, out_imm=0xFFFFFFFF, out_operand1=0, out_tag1=0, rename_en pulsed with rename_reg=5, rename_tag=rob_alloc_tag=3.
- ADD x3,x1,x2 with x1 busy tag 2 (rob_ready1=1, value 0x10) and x2 busy tag 4 (not ready) -> out_operand1=0x10, out_tag1=0, out_operand2=0, out_tag2=4.
- rs_full held 3 cycles with 2 queued instructions -> no dispatch and inst_ready=0 during the stall; after release, two consecutive dispatch_valid pulses in program order.
- flush together with inst_valid while HELD -> no dispatch and no rename; next cycle d_valid=0.
- With DECODE_CDB_BYPASS_EN: pending tag 4 and cdb_tag=4, cdb_value=0x55 in the fire cycle -> out_operand2=0x55, out_tag2=0.

Source files
------------

// File: rtl/decode_dispatch_if.sv
// Bus bundle for the decode/dispatch stage: instruction queue, regfile,
// ROB, rename, dispatch packet and CDB signals.
interface decode_dispatch_if #(
   parameter int XLEN      = 32,
   parameter int ROB_WIDTH = 4,
   parameter int OP_WIDTH  = 6,
   parameter int REG_WIDTH = 5
) ();
   logic                 flush;
   logic                 inst_valid;
   logic [31:0]          inst;
   logic [XLEN-1:0]      inst_pc;
   logic                 inst_ready;
   logic [REG_WIDTH-1:0] rs1;
   logic [REG_WIDTH-1:0] rs2;
   logic [XLEN-1:0]      reg_value1;
   logic [XLEN-1:0]      reg_value2;
   logic                 reg_busy1;
   logic                 reg_busy2;
   logic [ROB_WIDTH-1:0] reg_tag1;
   logic [ROB_WIDTH-1:0] reg_tag2;
   logic [ROB_WIDTH-1:0] query_tag1;
   logic [ROB_WIDTH-1:0] query_tag2;
   logic                 rob_ready1;
   logic                 rob_ready2;
   logic [XLEN-1:0]      rob_value1;
   logic [XLEN-1:0]      rob_value2;
   logic [ROB_WIDTH-1:0] rob_alloc_tag;
   logic                 rob_full;
   logic                 rs_full;
   logic                 rename_en;
   logic [REG_WIDTH-1:0] rename_reg;
   logic [ROB_WIDTH-1:0] rename_tag;
   logic                 dispatch_valid;
   logic [OP_WIDTH-1:0]  out_op;
   logic [XLEN-1:0]      out_imm;
   logic [XLEN-1:0]      out_pc;
   logic [REG_WIDTH-1:0] out_rd;
   logic [ROB_WIDTH-1:0] out_dest_tag;
   logic [XLEN-1:0]      out_operand1;
   logic [XLEN-1:0]      out_operand2;
   logic [ROB_WIDTH-1:0] out_tag1;
   logic [ROB_WIDTH-1:0] out_tag2;
   logic                 cdb_valid;
   logic [ROB_WIDTH-1:0] cdb_tag;
   logic [XLEN-1:0]      cdb_value;

   modport slave (
      input  flush, inst_valid, inst, inst_pc,
      input  reg_value1, reg_value2, reg_busy1, reg_busy2,
      input  reg_tag1, reg_tag2,
      input  rob_ready1, rob_ready2, rob_value1, rob_value2,
      input  rob_alloc_tag, rob_full, rs_full,
      input  cdb_valid, cdb_tag, cdb_value,
      output inst_ready, rs1, rs2, query_tag1, query_tag2,
      output rename_en, rename_reg, rename_tag,
      output dispatch_valid, out_op, out_imm, out_pc, out_rd,
      output out_dest_tag, out_operand1, out_operand2,
      output out_tag1, out_tag2
   );

   modport master (
      output flush, inst_valid, inst, inst_pc,
      output reg_value1, reg_value2, reg_busy1, reg_busy2,
      output reg_tag1, reg_tag2,
      output rob_ready1, rob_ready2, rob_value1, rob_value2,
      output rob_alloc_tag, rob_full, rs_full,
      output cdb_valid, cdb_tag, cdb_value,
      input  inst_ready, rs1, rs2, query_tag1, query_tag2,
      input  rename_en, rename_reg, rename_tag,
      input  dispatch_valid, out_op, out_imm, out_pc, out_rd,
      input  out_dest_tag, out_operand1, out_operand2,
      input  out_tag1, out_tag2
   );
endinterface

// File: rtl/decode_dispatch.sv
// RV32I decode-and-dispatch stage with operand resolution and rename.
// Define DECODE_CDB_BYPASS_EN to capture CDB results for pending sources.
module decode_dispatch #(
   parameter int XLEN      = 32,
   parameter int ROB_WIDTH = 4,
   parameter int OP_WIDTH  = 6,
   parameter int REG_WIDTH = 5
) (
   input logic clk,
   input logic rst,
   decode_dispatch_if.slave io
);
   localparam logic [OP_WIDTH-1:0] OP_NOP   = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_SLTU  = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(8);
   localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(9);
   localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(10);
   localparam logic [OP_WIDTH-1:0] OP_LUI   = OP_WIDTH'(11);
   localparam logic [OP_WIDTH-1:0] OP_AUIPC = OP_WIDTH'(12);
   localparam logic [OP_WIDTH-1:0] OP_JAL   = OP_WIDTH'(13);
   localparam logic [OP_WIDTH-1:0] OP_JALR  = OP_WIDTH'(14);
   localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(15);
   localparam logic [OP_WIDTH-1:0] OP_BNE   = OP_WIDTH'(16);
   localparam logic [OP_WIDTH-1:0] OP_BLT   = OP_WIDTH'(17);
   localparam logic [OP_WIDTH-1:0] OP_BGE   = OP_WIDTH'(18);
   localparam logic [OP_WIDTH-1:0] OP_BLTU  = OP_WIDTH'(19);
   localparam logic [OP_WIDTH-1:0] OP_BGEU  = OP_WIDTH'(20);
   localparam logic [OP_WIDTH-1:0] OP_LB    = OP_WIDTH'(21);
   localparam logic [OP_WIDTH-1:0] OP_LH    = OP_WIDTH'(22);
   localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(23);
   localparam logic [OP_WIDTH-1:0] OP_LBU   = OP_WIDTH'(24);
   localparam logic [OP_WIDTH-1:0] OP_LHU   = OP_WIDTH'(25);
   localparam logic [OP_WIDTH-1:0] OP_SB    = OP_WIDTH'(26);
   localparam logic [OP_WIDTH-1:0] OP_SH    = OP_WIDTH'(27);
   localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(28);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic [OP_WIDTH-1:0]  op;
      logic [31:0]          imm;
      logic [REG_WIDTH-1:0] rd;
      logic [REG_WIDTH-1:0] s1;
      logic [REG_WIDTH-1:0] s2;
   } dec_t;

   typedef struct packed {
      logic [XLEN-1:0]      val;
      logic [ROB_WIDTH-1:0] tag;
   } res_t;

   function automatic logic [OP_WIDTH-1:0] alu_op(
      input logic [2:0] f3,
      input logic       alt,
      input logic       reg_form
   );
      case (f3)
         3'b000:  alu_op = (reg_form && alt) ? OP_SUB : OP_ADD;
         3'b001:  alu_op = OP_SLL;
         3'b010:  alu_op = OP_SLT;
         3'b011:  alu_op = OP_SLTU;
         3'b100:  alu_op = OP_XOR;
         3'b101:  alu_op = alt ? OP_SRA : OP_SRL;
         3'b110:  alu_op = OP_OR;
         default: alu_op = OP_AND;
      endcase
   endfunction

   function automatic res_t resolve(
      input logic [REG_WIDTH-1:0] rs,
      input logic                 busy,
      input logic [ROB_WIDTH-1:0] tag,
      input logic                 rdy,
      input logic [XLEN-1:0]      rval,
      input logic [XLEN-1:0]      bval
   );
      res_t r;
      r = '0;
      if (rs != '0) begin
         if (!busy)
            r.val = rval;
         else if (rdy)
            r.val = bval;
         else
            r.tag = tag;
      end
      return r;
   endfunction

   logic                 d_valid;
   logic [31:0]          d_inst;
   logic [XLEN-1:0]      d_pc;
   logic                 fire;
   logic                 capture;
   logic                 legal;
   dec_t                 dec;
   res_t                 res1;
   res_t                 res2;
   logic [6:0]           opc;
   logic [2:0]           f3;
   logic [31:0]          imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [REG_WIDTH-1:0] rd_f, rs1_f, rs2_f;

   assign opc   = d_inst[6:0];
   assign f3    = d_inst[14:12];
   assign rd_f  = REG_WIDTH'(d_inst[11:7]);
   assign rs1_f = REG_WIDTH'(d_inst[19:15]);
   assign rs2_f = REG_WIDTH'(d_inst[24:20]);

   assign imm_i = {{20{d_inst[31]}}, d_inst[31:20]};
   assign imm_s = {{20{d_inst[31]}}, d_inst[31:25], d_inst[11:7]};
   assign imm_b = {{19{d_inst[31]}}, d_inst[31], d_inst[7],
                   d_inst[30:25], d_inst[11:8], 1'b0};
   assign imm_u = {d_inst[31:12], 12'b0};
   assign imm_j = {{11{d_inst[31]}}, d_inst[31], d_inst[19:12],
                   d_inst[20], d_inst[30:21], 1'b0};

   always_comb begin
      dec   = '0;
      legal = 1'b1;
      case (opc)
         OPC_OPIMM: begin
            dec.op  = alu_op(f3, d_inst[30], 1'b0);
            dec.imm = imm_i;
            dec.rd  = rd_f;
            dec.s1  = rs1_f;
         end
         OPC_OP: begin
            dec.op = alu_op(f3, d_inst[30], 1'b1);
            dec.rd = rd_f;
            dec.s1 = rs1_f;
            dec.s2 = rs2_f;
         end
         OPC_LUI: begin
            dec.op  = OP_LUI;
            dec.imm = imm_u;
            dec.rd  = rd_f;
         end
         OPC_AUIPC: begin
            dec.op  = OP_AUIPC;
            dec.imm = imm_u;
            dec.rd  = rd_f;
         end
         OPC_JAL: begin
            dec.op  = OP_JAL;
            dec.imm = imm_j;
            dec.rd  = rd_f;
         end
         OPC_JALR: begin
            if (f3 == 3'b000) begin
               dec.op  = OP_JALR;
               dec.imm = imm_i;
               dec.rd  = rd_f;
               dec.s1  = rs1_f;
            end
         end
         OPC_BRANCH: begin
            case (f3)
               3'b000:  dec.op = OP_BEQ;
               3'b001:  dec.op = OP_BNE;
               3'b100:  dec.op = OP_BLT;
               3'b101:  dec.op = OP_BGE;
               3'b110:  dec.op = OP_BLTU;
               3'b111:  dec.op = OP_BGEU;
               default: legal  = 1'b0;
            endcase
            if (legal) begin
               dec.imm = imm_b;
               dec.s1  = rs1_f;
               dec.s2  = rs2_f;
            end
         end
         OPC_LOAD: begin
            case (f3)
               3'b000:  dec.op = OP_LB;
               3'b001:  dec.op = OP_LH;
               3'b010:  dec.op = OP_LW;
               3'b100:  dec.op = OP_LBU;
               3'b101:  dec.op = OP_LHU;
               default: legal  = 1'b0;
            endcase
            if (legal) begin
               dec.imm = imm_i;
               dec.rd  = rd_f;
               dec.s1  = rs1_f;
            end
         end
         OPC_STORE: begin
            case (f3)
               3'b000:  dec.op = OP_SB;
               3'b001:  dec.op = OP_SH;
               3'b010:  dec.op = OP_SW;
               default: legal  = 1'b0;
            endcase
            if (legal) begin
               dec.imm = imm_s;
               dec.s1  = rs1_f;
               dec.s2  = rs2_f;
            end
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      res1 = resolve(dec.s1, io.reg_busy1, io.reg_tag1,
                     io.rob_ready1, io.reg_value1, io.rob_value1);
      res2 = resolve(dec.s2, io.reg_busy2, io.reg_tag2,
                     io.rob_ready2, io.reg_value2, io.rob_value2);
`ifdef DECODE_CDB_BYPASS_EN
      // A nonzero tag here already means the ROB lacked the result.
      if (res1.tag != '0 && io.cdb_valid && io.cdb_tag == res1.tag) begin
         res1.val = io.cdb_value;
         res1.tag = '0;
      end
      if (res2.tag != '0 && io.cdb_valid && io.cdb_tag == res2.tag) begin
         res2.val = io.cdb_value;
         res2.tag = '0;
      end
`endif
   end

`ifndef DECODE_CDB_BYPASS_EN
   logic unused_cdb;
   assign unused_cdb = ^{io.cdb_valid, io.cdb_tag, io.cdb_value};
`endif

   assign fire    = d_valid && !io.rob_full && !io.rs_full && !io.flush;
   assign capture = io.inst_valid && io.inst_ready && !io.flush;

   assign io.inst_ready = !d_valid || fire;
   assign io.rs1        = dec.s1;
   assign io.rs2        = dec.s2;
   assign io.query_tag1 = (dec.s1 != '0 && io.reg_busy1) ? io.reg_tag1 : '0;
   assign io.query_tag2 = (dec.s2 != '0 && io.reg_busy2) ? io.reg_tag2 : '0;
   assign io.rename_en  = fire && (dec.rd != '0);
   assign io.rename_reg = dec.rd;
   assign io.rename_tag = io.rob_alloc_tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         d_valid           <= 1'b0;
         d_inst            <= '0;
         d_pc              <= '0;
         io.dispatch_valid <= 1'b0;
         io.out_op         <= OP_NOP;
         io.out_imm        <= '0;
         io.out_pc         <= '0;
         io.out_rd         <= '0;
         io.out_dest_tag   <= '0;
         io.out_operand1   <= '0;
         io.out_operand2   <= '0;
         io.out_tag1       <= '0;
         io.out_tag2       <= '0;
      end else begin
         io.dispatch_valid <= fire;
         if (io.flush) begin
            d_valid <= 1'b0;
         end else if (capture) begin
            d_valid <= 1'b1;
            d_inst  <= io.inst;
            d_pc    <= io.inst_pc;
         end else if (fire) begin
            d_valid <= 1'b0;
         end
         if (fire) begin
            io.out_op       <= dec.op;
            io.out_imm      <= XLEN'($signed(dec.imm));
            io.out_pc       <= d_pc;
            io.out_rd       <= dec.rd;
            io.out_dest_tag <= io.rob_alloc_tag;
            io.out_operand1 <= res1.val;
            io.out_operand2 <= res2.val;
            io.out_tag1     <= res1.tag;
            io.out_tag2     <= res2.tag;
         end
      end
   end
endmodule
